// File: rtl/lattice_pkg.sv
// Shared lattice constants: frame geometry, D2Q9 direction lane indices and packer FSM encoding.
package lattice_pkg;
  localparam int DATA_WIDTH    = 16;
  localparam int NUM_DIR       = 9;
  localparam int DEPTH         = 2500;
  localparam int ADDRESS_WIDTH = 12;

  // Lane index of each direction inside the packed pixel, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
  localparam int DIR_N    = 0;
  localparam int DIR_NULL = 1;
  localparam int DIR_NE   = 2;
  localparam int DIR_E    = 3;
  localparam int DIR_SE   = 4;
  localparam int DIR_S    = 5;
  localparam int DIR_SW   = 6;
  localparam int DIR_W    = 7;
  localparam int DIR_NW   = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with registered occupancy count and a combinational head word.
module axis_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign dout   = mem[rptr];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the head is only looked at while count is non-zero
  always_ff @(posedge aclk) begin
    if (push) mem[wptr] <= din;
  end

`ifndef SYNTHESIS
  always_ff @(posedge aclk) begin
    if (aresetn && push && !do_pop) assert (count != CW'(DEPTH));
  end
`endif
endmodule

// File: rtl/lattice_axis_packer.sv
// Streams one D2Q9 lattice frame from nine direction BRAMs onto a 144-bit AXI-Stream master.
// Define LATTICE_PACKER_SOF_TUSER_EN to add m00_axis_tuser[0] marking pixel 0 of each frame.
module lattice_axis_packer
  import lattice_pkg::*;
#(
  parameter int DATA_WIDTH    = lattice_pkg::DATA_WIDTH,
  parameter int NUM_DIR       = lattice_pkg::NUM_DIR,
  parameter int DEPTH         = lattice_pkg::DEPTH,
  parameter int ADDRESS_WIDTH = lattice_pkg::ADDRESS_WIDTH,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          m00_axis_aclk,
  input  logic                          m00_axis_aresetn,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [ADDRESS_WIDTH-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0]         rd_n,
  input  logic [DATA_WIDTH-1:0]         rd_null,
  input  logic [DATA_WIDTH-1:0]         rd_ne,
  input  logic [DATA_WIDTH-1:0]         rd_e,
  input  logic [DATA_WIDTH-1:0]         rd_se,
  input  logic [DATA_WIDTH-1:0]         rd_s,
  input  logic [DATA_WIDTH-1:0]         rd_sw,
  input  logic [DATA_WIDTH-1:0]         rd_w,
  input  logic [DATA_WIDTH-1:0]         rd_nw,
  output logic                          m00_axis_tvalid,
  output logic [NUM_DIR*DATA_WIDTH-1:0] m00_axis_tdata,
  output logic [NUM_DIR*DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                          m00_axis_tlast,
`ifdef LATTICE_PACKER_SOF_TUSER_EN
  output logic [0:0]                    m00_axis_tuser,
`endif
  input  logic                          m00_axis_tready
);
  localparam int TW = NUM_DIR * DATA_WIDTH;
`ifdef LATTICE_PACKER_SOF_TUSER_EN
  localparam int FW = TW + 2;
`else
  localparam int FW = TW + 1;
`endif
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]                         state;
  logic [1:0]                         vld_pipe;
  logic                               last_q;
  logic [NUM_DIR-1:0][DATA_WIDTH-1:0] lanes;
  logic [FW-1:0]                      fifo_din, fifo_dout;
  logic [CW-1:0]                      fifo_count;
  logic                               fifo_empty;
  logic                               pop, head_last, issue_last;

  assign lanes[DIR_N]    = rd_n;
  assign lanes[DIR_NULL] = rd_null;
  assign lanes[DIR_NE]   = rd_ne;
  assign lanes[DIR_E]    = rd_e;
  assign lanes[DIR_SE]   = rd_se;
  assign lanes[DIR_S]    = rd_s;
  assign lanes[DIR_SW]   = rd_sw;
  assign lanes[DIR_W]    = rd_w;
  assign lanes[DIR_NW]   = rd_nw;

  // Occupancy plus the read still in the BRAM pipe bounds what may be outstanding
  assign rd_en       = (state == ST_READ) &&
                       (({1'b0, fifo_count} + {{CW{1'b0}}, vld_pipe[1]}) < (CW+1)'(FIFO_DEPTH));
  assign vld_pipe[0] = rd_en;
  assign issue_last  = (rd_addr == ADDRESS_WIDTH'(DEPTH - 1));
  assign busy        = (state != ST_IDLE);

  assign m00_axis_tvalid = !fifo_empty;
  assign pop             = m00_axis_tvalid && m00_axis_tready;
  assign head_last       = fifo_dout[TW];
  assign m00_axis_tdata  = m00_axis_tvalid ? fifo_dout[TW-1:0] : '0;
  assign m00_axis_tlast  = m00_axis_tvalid && head_last;
  assign m00_axis_tstrb  = {(TW/8){m00_axis_tvalid}};

`ifdef LATTICE_PACKER_SOF_TUSER_EN
  logic sof_q;
  assign fifo_din          = {sof_q, last_q, lanes};
  assign m00_axis_tuser[0] = m00_axis_tvalid && fifo_dout[TW+1];

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) sof_q <= 1'b0;
    else                   sof_q <= (rd_addr == '0);
  end
`else
  assign fifo_din = {last_q, lanes};
`endif

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state       <= ST_IDLE;
      rd_addr     <= '0;
      vld_pipe[1] <= 1'b0;
      last_q      <= 1'b0;
      done        <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      last_q      <= issue_last;
      done        <= pop && head_last;
      case (state)
        ST_IDLE: if (start) begin
          state   <= ST_READ;
          rd_addr <= '0;
        end
        ST_READ: if (rd_en) begin
          if (issue_last) state <= ST_DRAIN;
          else            rd_addr <= rd_addr + ADDRESS_WIDTH'(1);
        end
        ST_DRAIN: if (pop && head_last) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .aclk    (m00_axis_aclk),
    .aresetn (m00_axis_aresetn),
    .push    (vld_pipe[1]),
    .din     (fifo_din),
    .pop     (pop),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );
endmodule

// File: tb/tb_lattice_axis_packer.sv
// Bench for lattice_axis_packer: frame-level model (read/accept counters) checked every cycle plus directed scenarios.
module tb_lattice_axis_packer;
  localparam int NPIX = 2500;
  localparam int FD   = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         tready = 1'b1;
  logic         busy, done, rd_en, tvalid, tlast;
  logic [11:0]  rd_addr;
  logic [143:0] tdata;
  logic [17:0]  tstrb;
  logic [15:0]  rd_n, rd_null, rd_ne, rd_e, rd_se, rd_s, rd_sw, rd_w, rd_nw;
`ifdef LATTICE_PACKER_SOF_TUSER_EN
  logic [0:0]   tuser;
`endif

  lattice_axis_packer dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_n(rd_n), .rd_null(rd_null), .rd_ne(rd_ne), .rd_e(rd_e), .rd_se(rd_se),
    .rd_s(rd_s), .rd_sw(rd_sw), .rd_w(rd_w), .rd_nw(rd_nw),
    .m00_axis_tvalid(tvalid), .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb),
    .m00_axis_tlast(tlast),
`ifdef LATTICE_PACKER_SOF_TUSER_EN
    .m00_axis_tuser(tuser),
`endif
    .m00_axis_tready(tready)
  );

  always #5 clk = ~clk;

  // Direction d of pixel k holds d*0x1000 + k
  function automatic logic [15:0] f(int d, int k);
    return 16'(d * 4096 + k);
  endfunction

  function automatic logic [143:0] pix(int k);
    logic [143:0] p;
    for (int d = 0; d < 9; d++) p[d*16 +: 16] = f(d, k);
    return p;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      rd_n  <= f(0, int'(rd_addr)); rd_null <= f(1, int'(rd_addr)); rd_ne <= f(2, int'(rd_addr));
      rd_e  <= f(3, int'(rd_addr)); rd_se   <= f(4, int'(rd_addr)); rd_s  <= f(5, int'(rd_addr));
      rd_sw <= f(6, int'(rd_addr)); rd_w    <= f(7, int'(rd_addr)); rd_nw <= f(8, int'(rd_addr));
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model state: reads issued / beats accepted in the current frame
  int iss = 0, iss_d1 = 0, acc = 0, frame_beats = 0;
  bit busy_m = 0, done_e = 0, hold = 0;
  logic [143:0] prev_d, last_data;
  logic prev_l;

  always @(negedge clk) begin
    bit exp_v, exp_rd, busy_now;
    if (!rst_n) begin
      iss = 0; iss_d1 = 0; acc = 0; busy_m = 0; done_e = 0; hold = 0;
    end else begin
      exp_rd = busy_m && (iss < NPIX) && ((iss - acc) < FD);
      exp_v  = iss_d1 > acc;
      chk("rd_en", 144'(rd_en), 144'(exp_rd));
      if (rd_en) chk("rd_addr", 144'(rd_addr), 144'(iss));
      chk("tvalid", 144'(tvalid), 144'(exp_v));
      chk("tstrb", 144'(tstrb), 144'({18{exp_v}}));
      chk("busy", 144'(busy), 144'(busy_m));
      chk("done", 144'(done), 144'(done_e));
      if (hold) begin
        chk("hold_valid", 144'(tvalid), 144'(1));
        chk("hold_data", tdata, prev_d);
        chk("hold_last", 144'(tlast), 144'(prev_l));
      end
      if (tvalid) begin
        chk("tdata", tdata, pix(acc));
        chk("tlast", 144'(tlast), 144'(acc == NPIX - 1));
`ifdef LATTICE_PACKER_SOF_TUSER_EN
        chk("tuser", 144'(tuser), 144'(acc == 0));
`endif
      end
      hold = tvalid && !tready; prev_d = tdata; prev_l = tlast;
      busy_now = busy_m;
      done_e = tvalid && tready && tlast;
      if (tvalid && tready) begin
        if (tlast) begin frame_beats = acc + 1; last_data = tdata; busy_m = 0; end
        acc++;
      end
      iss_d1 = iss;
      if (rd_en) iss++;
      if (start && !busy_now) begin
        busy_m = 1; iss = 0; iss_d1 = 0; acc = 0; frame_beats = 0;
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 144'(busy), 144'(0));
    chk({tag, "_done"}, 144'(done), 144'(0));
    chk({tag, "_rd_en"}, 144'(rd_en), 144'(0));
    chk({tag, "_rd_addr"}, 144'(rd_addr), 144'(0));
    chk({tag, "_tvalid"}, 144'(tvalid), 144'(0));
    chk({tag, "_tdata"}, tdata, 144'(0));
    chk({tag, "_tstrb"}, 144'(tstrb), 144'(0));
    chk({tag, "_tlast"}, 144'(tlast), 144'(0));
`ifdef LATTICE_PACKER_SOF_TUSER_EN
    chk({tag, "_tuser"}, 144'(tuser), 144'(0));
`endif
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Runs until done is seen; inj >= 0 pulses start while beat inj is being accepted
  task automatic run_frame(input int budget, input bit rnd, input int inj, input string tag);
    bit got = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      start = (inj >= 0) && (acc == inj);
      if (done) begin got = 1; break; end
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start = 1'b0;
    tready = 1'b1;
    chk({tag, "_done_seen"}, 144'(got), 144'(1));
    chk({tag, "_beats"}, 144'(frame_beats), 144'(NPIX));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_idle("reset");
    rst_n = 1'b1;

    // 1: full-rate frame, latency and literal lane values
    pulse_start();
    chk("t1_lat0", 144'(tvalid), 144'(0));
    @(posedge clk); #1 chk("t1_lat1", 144'(tvalid), 144'(0));
    @(posedge clk); #1 chk("t1_lat2", 144'(tvalid), 144'(1));
    chk("t1_b0_n", 144'(tdata[15:0]), 144'(16'h0000));
    chk("t1_b0_e", 144'(tdata[63:48]), 144'(16'h3000));
    chk("t1_b0_nw", 144'(tdata[143:128]), 144'(16'h8000));
    run_frame(3000, 0, -1, "t1");
    chk("t1_last_n", 144'(last_data[15:0]), 144'(16'h09C3));
    chk("t1_last_nw", 144'(last_data[143:128]), 144'(16'h89C3));
    @(posedge clk); #1;
    chk("t1_busy_after", 144'(busy), 144'(0));
    chk("t1_done_after", 144'(done), 144'(0));

    // 2: random backpressure
    pulse_start();
    run_frame(8000, 1, -1, "t2");

    // 3: stalled consumer fills exactly FD entries
    tready = 1'b0;
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    chk("t3_reads", 144'(iss), 144'(4));
    chk("t3_rd_en", 144'(rd_en), 144'(0));
    chk("t3_head", 144'(tdata[31:16]), 144'(16'h1000));
    run_frame(3000, 0, -1, "t3");

    // 4: start while busy is ignored
    pulse_start();
    run_frame(3000, 0, 100, "t4");

    // 5: asynchronous reset mid-frame, then a clean frame
    pulse_start();
    for (int c = 0; c < 2000 && acc < 1200; c++) @(posedge clk);
    chk("t5_reached", 144'(acc >= 1200), 144'(1));
    #1 rst_n = 1'b0;
    #1 chk_idle("t5_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    pulse_start();
    run_frame(3000, 0, -1, "t5");

    // 6: back-to-back frames, second start in the done cycle
    pulse_start();
    run_frame(3000, 0, -1, "t6a");
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("t6_restart", 144'(busy), 144'(1));
    run_frame(3000, 0, -1, "t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
